// File: rtl/credit_arb_pkg.sv
// Shared sizes, FSM state type and saturating adder for the credit arbiter.
// The starvation guard is built only when CREDIT_ARB_STARVE_EN is defined.
package credit_arb_pkg;

  localparam int NREQ       = 4;
  localparam int CW         = 4;
  localparam int AW         = 2;
  localparam int PW         = 2;
  localparam int STARVE_MAX = 7;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  // Adds a small return amount to the pool, clamping at the pool maximum.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [AW-1:0] b);
    logic [CW:0] sum;
    sum = {1'b0, a} + {{(CW-AW+1){1'b0}}, b};
    return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
  endfunction

endpackage

// File: rtl/credit_rr_pick.sv
// Rotating-priority picker: first set bit of eligible at or after ptr,
// scanning upward modulo NREQ. Purely combinational.
module credit_rr_pick
  import credit_arb_pkg::*;
(
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + PW'(k);
      if (!valid && eligible[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/credit_arbiter.sv
// Credit-pool arbiter: four requesters consume from a shared pool, one grant
// per cycle in round-robin order. Define CREDIT_ARB_STARVE_EN for the starvation guard.
module credit_arbiter
  import credit_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        cfg_initial,
  input  logic                 reinit_req,
  output logic                 reinit_ack,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_amt,
  output logic [NREQ-1:0]      req_grant,
  input  logic                 ret_valid,
  input  logic [AW-1:0]        ret_amt,
  output logic [CW-1:0]        credits,
  output logic [CW-1:0]        credits_next
);

  // Handshake: a requester holds req_valid/req_amt until it sees req_grant in
  // the same cycle; the grant is the consume strobe. ret_valid is a one-cycle
  // strobe with no backpressure. reinit_ack marks the cycle the reload lands.

  arb_state_t      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [CW-1:0]   avail;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick_in;
  logic [NREQ-1:0] pick_grant;
  logic            pick_valid;
  logic [AW-1:0]   grant_amt;
  logic [PW-1:0]   grant_idx;
  logic            grant_en;

  // Returns are folded in before the eligibility test so they can enable a grant.
  always_comb begin
    avail = ret_valid ? sat_add(credits_q, ret_amt) : credits_q;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && ({{(CW-AW){1'b0}}, req_amt[AW*i +: AW]} <= avail);
    end
  end

`ifdef CREDIT_ARB_STARVE_EN
  logic [2:0]      wait_q [NREQ];
  logic [NREQ-1:0] starved;
  logic [NREQ-1:0] pin_grant;
  logic            pin_valid;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      starved[i] = req_valid[i] && (wait_q[i] == 3'(STARVE_MAX));
    end
  end

  credit_rr_pick u_pin_pick (
    .eligible (starved),
    .ptr      (rr_ptr_q),
    .grant    (pin_grant),
    .valid    (pin_valid)
  );

  // A pinned requester blocks everyone else, even while it cannot yet afford its amount.
  assign pick_in = pin_valid ? (eligible & pin_grant) : eligible;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !req_grant[i]) begin
          if (wait_q[i] != 3'(STARVE_MAX)) wait_q[i] <= wait_q[i] + 3'd1;
        end else begin
          wait_q[i] <= '0;
        end
      end
    end
  end
`else
  assign pick_in = eligible;
`endif

  credit_rr_pick u_pick (
    .eligible (pick_in),
    .ptr      (rr_ptr_q),
    .grant    (pick_grant),
    .valid    (pick_valid)
  );

  always_comb begin
    grant_amt = '0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        grant_amt = req_amt[AW*i +: AW];
        grant_idx = PW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    credits_d  = credits_q;
    reinit_ack = 1'b0;
    grant_en   = 1'b0;
    req_grant  = '0;
    case (state_q)
      INIT: begin
        reinit_ack = 1'b1;
        credits_d  = cfg_initial;
        state_d    = RUN;
      end
      RUN: begin
        grant_en  = !reinit_req;
        credits_d = avail;
        if (grant_en && pick_valid) begin
          req_grant = pick_grant;
          credits_d = avail - {{(CW-AW){1'b0}}, grant_amt};
          rr_ptr_d  = grant_idx + PW'(1);
        end
        if (reinit_req) state_d = INIT;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      rr_ptr_q  <= '0;
      credits_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      credits_q <= credits_d;
    end
  end

  assign credits      = credits_q;
  assign credits_next = credits_d;

endmodule

// File: doc/credit_arbiter.md
CREDIT_ARBITER -- requirements
Module: credit_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk is the only clock, and rst is asynchronous and active-high.
REQ-002 Port list:
  - clk  in  1  clock; all state updates on its rising edge.
  - rst  in  1  asynchronous active-high reset.
  - cfg_initial  in  4  credit pool load value.
  - reinit_req  in  1  request to reload the pool from cfg_initial.
  - reinit_ack  out  1  pool reload taking effect this cycle.
  - req_valid  in  4  per-requester consume request; held until granted.
  - req_amt  in  8  per-requester 2-bit consume amount; requester i uses bits [2i+1:2i].
  - req_grant  out  4  one-hot or zero grant, combinational.
  - ret_valid  in  1  credit return strobe.
  - ret_amt  in  2  credits returned.
  - credits  out  4  registered pool value.
  - credits_next  out  4  combinational next pool value.

Function
REQ-003 The FSM SHALL have two states:
  - INIT: reinit_ack=1; req_grant=0; ret ignored; credits<=cfg_initial; next state RUN.
  - RUN: arbitrate; if reinit_req=1, grants SHALL be suppressed that cycle, returns SHALL still apply, and next state SHALL be INIT.
REQ-004 In RUN, avail SHALL equal credits+ret_amt when ret_valid=1, saturated at 15; otherwise avail=credits.
REQ-005 Requester i SHALL be eligible when req_valid[i]=1 and req_amt[i]<=avail; req_amt=0 SHALL be eligible.
REQ-006 At most one grant SHALL be issued per cycle, to the first eligible requester at or after rr_ptr in ascending modulo-4 order.
REQ-007 After a grant to requester i, rr_ptr SHALL become (i+1) mod 4; with no grant, rr_ptr SHALL hold.
REQ-008 credits_next SHALL equal avail minus the granted amount (avail when no grant); it never underflows, by REQ-005.
REQ-009 Grant and return in the same cycle SHALL both take effect, the return first (a return can enable a grant).
REQ-010 An ineligible requester SHALL NOT block an eligible requester later in the rotation.
REQ-011 credits SHALL register credits_next every cycle in RUN; in INIT it SHALL be loaded per REQ-003.

Reset
REQ-012 While rst=1: state=INIT, credits=0, rr_ptr=0, starvation counters=0 (when built).
REQ-013 Outputs during reset SHALL be req_grant=0 and reinit_ack=1, since state is INIT.
REQ-014 The first clock after rst deasserts SHALL load cfg_initial; mid-operation reset SHALL drop any in-flight grant with no partial update.

Configuration
REQ-015 With macro CREDIT_ARB_STARVE_EN defined:
  - each requester SHALL have a 3-bit wait counter that increments while req_valid=1 and the requester is not granted, and clears on grant or !req_valid;
  - when a counter saturates at 7, that requester SHALL be pinned: all other grants SHALL be blocked until the pinned requester is granted;
  - with several saturated requesters, the lowest index at or after rr_ptr SHALL be pinned.
REQ-016 Without CREDIT_ARB_STARVE_EN, the counters SHALL NOT exist and the block SHALL behave as pure REQ-006 round-robin.

Structure
REQ-017 Package credit_arb_pkg SHALL hold NREQ=4, CW=4, AW=2, STARVE_MAX=7, and the state enum {INIT, RUN}.
REQ-018 The rotate-priority pick SHALL be a sub-module credit_rr_pick (inputs eligible[3:0] and ptr[1:0]; outputs a one-hot grant and a valid flag).

Verification
REQ-019 Reset release with cfg_initial=9 -> cycle 1: reinit_ack=1, no grant; cycle 2: credits=9, RUN.
REQ-020 credits=2, all four requesting amt=1, rr_ptr=0 -> grants 0 then 1; credits reach 0; req 2 is not granted; credits=0 holds.
REQ-021 credits=0, req0 amt=3, ret_valid with ret_amt=3 in the same cycle -> req0 granted that cycle; credits_next=0.
REQ-022 credits=14, ret_amt=3, no requests -> credits=15 (saturated).
REQ-023 reinit_req while req1 is pending, cfg_initial=5 -> no grant that cycle; one reinit_ack cycle; credits=5; req1 is then granted in RUN.
REQ-024 With CREDIT_ARB_STARVE_EN: credits=1, req3 amt=2 starving while req0 amt=1 repeatedly returns and re-requests -> after 7 waiting cycles req0 is blocked until credits reach 2 and req3 is granted.
